// File: rtl/btb_assoc.sv
// ============================================================================
// Module   : btb_assoc
// Purpose  : N-way set-associative branch target buffer with 2-bit direction
//            counters, round-robin replacement and a multi-cycle flush walker.
// Revision : 1.0
// ============================================================================
`default_nettype none

module btb_assoc #(
    parameter int SETS = 16,
    parameter int WAYS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lookup_pc,
    output logic        hit,
    output logic [31:0] pred_target,
    output logic        pred_branch,
    output logic        pred_jump,
    output logic        pred_taken,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_branch,
    input  logic        upd_taken,
    input  logic        flush,
    output logic        busy
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;
    localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    logic [WAYS-1:0]  valid_q  [SETS];
    logic [WAYS-1:0]  valid_d  [SETS];
    logic [WAYS-1:0]  branch_q [SETS];
    logic [WAYS-1:0]  branch_d [SETS];
    logic [PTR_W-1:0] ptr_q    [SETS];
    logic [PTR_W-1:0] ptr_d    [SETS];
    logic [1:0]       ctr_q    [SETS][WAYS];
    logic [1:0]       ctr_d    [SETS][WAYS];
    logic [TAG_W-1:0] tag_q    [SETS][WAYS];
    logic [TAG_W-1:0] tag_d    [SETS][WAYS];
    logic [31:0]      target_q [SETS][WAYS];
    logic [31:0]      target_d [SETS][WAYS];

    logic [IDX_W-1:0] lk_set;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_found;
    logic [IDX_W-1:0] up_set;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic             up_inv;
    logic [PTR_W-1:0] up_hit_way;
    logic [PTR_W-1:0] up_inv_way;
    logic [PTR_W-1:0] up_way;
    logic             unused_pc_lsbs;

    assign lk_set = lookup_pc[1+IDX_W:2];
    assign lk_tag = lookup_pc[31:2+IDX_W];
    assign up_set = upd_pc[1+IDX_W:2];
    assign up_tag = upd_pc[31:2+IDX_W];
    assign busy   = (state_q == ST_FLUSH);
    assign unused_pc_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

    // Lookup: lowest matching way wins; everything reads as a miss while flushing.
    always_comb begin
        hit         = 1'b0;
        pred_target = 32'h0;
        pred_branch = 1'b0;
        pred_jump   = 1'b0;
        pred_taken  = 1'b0;
        lk_found    = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!lk_found && (state_q == ST_IDLE) && valid_q[lk_set][w]
                && (tag_q[lk_set][w] == lk_tag)) begin
                lk_found    = 1'b1;
                hit         = 1'b1;
                pred_target = target_q[lk_set][w];
                pred_branch = branch_q[lk_set][w];
                pred_jump   = !branch_q[lk_set][w];
                pred_taken  = !branch_q[lk_set][w] || ctr_q[lk_set][w][1];
            end
        end
    end

    // Way selection for the update port.
    always_comb begin
        up_hit     = 1'b0;
        up_inv     = 1'b0;
        up_hit_way = '0;
        up_inv_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!up_hit && valid_q[up_set][w] && (tag_q[up_set][w] == up_tag)) begin
                up_hit     = 1'b1;
                up_hit_way = PTR_W'(w);
            end
            if (!up_inv && !valid_q[up_set][w]) begin
                up_inv     = 1'b1;
                up_inv_way = PTR_W'(w);
            end
        end
        if (up_hit)      up_way = up_hit_way;
        else if (up_inv) up_way = up_inv_way;
        else             up_way = (WAYS > 1) ? ptr_q[up_set] : '0;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        branch_d = branch_q;
        ptr_d    = ptr_q;
        ctr_d    = ctr_q;
        tag_d    = tag_q;
        target_d = target_q;
        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end else if (upd_valid) begin
                    valid_d[up_set][up_way]  = 1'b1;
                    branch_d[up_set][up_way] = upd_branch;
                    tag_d[up_set][up_way]    = up_tag;
                    target_d[up_set][up_way] = upd_target;
                    if (up_hit) begin
                        if (!upd_branch)
                            ctr_d[up_set][up_way] = 2'd3;
                        else if (upd_taken && ctr_q[up_set][up_way] != 2'd3)
                            ctr_d[up_set][up_way] = ctr_q[up_set][up_way] + 2'd1;
                        else if (!upd_taken && ctr_q[up_set][up_way] != 2'd0)
                            ctr_d[up_set][up_way] = ctr_q[up_set][up_way] - 2'd1;
                    end else begin
                        ctr_d[up_set][up_way] = (!upd_branch || upd_taken) ? 2'd2 : 2'd1;
                        // Pointer only moves when a live entry is evicted.
                        if (!up_inv)
                            ptr_d[up_set] = (WAYS > 1) ? ptr_q[up_set] + PTR_W'(1) : '0;
                    end
                end
            end
            ST_FLUSH: begin
                if (flush) begin
                    cnt_d = '0;
                end else begin
                    valid_d[cnt_q] = '0;
                    ptr_d[cnt_q]   = '0;
                    cnt_d          = cnt_q + IDX_W'(1);
                    if (cnt_q == LAST_SET)
                        state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s]  <= '0;
                branch_q[s] <= '0;
                ptr_q[s]    <= '0;
                for (int w = 0; w < WAYS; w++)
                    ctr_q[s][w] <= 2'd0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            branch_q <= branch_d;
            ptr_q    <= ptr_d;
            ctr_q    <= ctr_d;
        end
        tag_q    <= tag_d;
        target_q <= target_d;
    end

endmodule

`default_nettype wire

// File: tb/tb_btb_assoc.sv
// ============================================================================
// Module   : tb_btb_assoc
// Purpose  : Scoreboard bench for btb_assoc (SETS=16, WAYS=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_btb_assoc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] lookup_pc = '0;
    logic        hit;
    logic [31:0] pred_target;
    logic        pred_branch;
    logic        pred_jump;
    logic        pred_taken;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic [31:0] upd_target = '0;
    logic        upd_branch = 1'b0;
    logic        upd_taken = 1'b0;
    logic        flush = 1'b0;
    logic        busy;

    typedef logic [36:0] vec_t;
    typedef struct {
        string tag;
        vec_t  v;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   n;

    btb_assoc #(.SETS(16), .WAYS(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .lookup_pc   (lookup_pc),
        .hit         (hit),
        .pred_target (pred_target),
        .pred_branch (pred_branch),
        .pred_jump   (pred_jump),
        .pred_taken  (pred_taken),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_target  (upd_target),
        .upd_branch  (upd_branch),
        .upd_taken   (upd_taken),
        .flush       (flush),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // {busy, hit, branch, jump, taken, target}
    function automatic vec_t mk(input logic b, input logic h, input logic br,
                                input logic j, input logic tk, input logic [31:0] t);
        return {b, h, br, j, tk, t};
    endfunction

    task automatic chk(input string tag, input vec_t got, input vec_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic probe(input string tag, input logic [31:0] pc, input vec_t e);
        exp_t x;
        lookup_pc = pc;
        sb_q.push_back('{tag, e});
        #1;
        x = sb_q.pop_front();
        chk(x.tag, {busy, hit, pred_branch, pred_jump, pred_taken, pred_target}, x.v);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt,
                       input logic br, input logic tk);
        upd_pc     = pc;
        upd_target = tgt;
        upd_branch = br;
        upd_taken  = tk;
        upd_valid  = 1'b1;
        @(posedge clk);
        #1;
        upd_valid  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    // Counts busy cycles from the current point; set 15 must read as a miss throughout.
    task automatic count_busy(output int cnt);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
            probe("flush_pred", 32'h03C, mk(1, 0, 0, 0, 0, 32'h0));
        end
    endtask

    initial begin
        do_reset();
        probe("reset_state", 32'h100, mk(0, 0, 0, 0, 0, 32'h0));

        // Counter behaviour, with no write-to-read bypass on the update cycle.
        upd_pc = 32'h100; upd_target = 32'h200; upd_branch = 1'b1; upd_taken = 1'b1;
        upd_valid = 1'b1;
        probe("no_bypass", 32'h100, mk(0, 0, 0, 0, 0, 32'h0));
        @(posedge clk); #1; upd_valid = 1'b0;
        probe("br_new_ctr2", 32'h100, mk(0, 1, 1, 0, 1, 32'h200));
        upd(32'h100, 32'h200, 1'b1, 1'b0);
        probe("br_ctr1", 32'h100, mk(0, 1, 1, 0, 0, 32'h200));
        upd(32'h100, 32'h200, 1'b1, 1'b0);
        probe("br_ctr0", 32'h100, mk(0, 1, 1, 0, 0, 32'h200));
        upd(32'h100, 32'h200, 1'b1, 1'b0);
        upd(32'h100, 32'h200, 1'b1, 1'b1);
        probe("br_sat_lo", 32'h100, mk(0, 1, 1, 0, 0, 32'h200));
        upd(32'h100, 32'h200, 1'b1, 1'b1);
        probe("br_ctr2_again", 32'h100, mk(0, 1, 1, 0, 1, 32'h200));

        // Replacement within set 0.
        do_reset();
        upd(32'h040, 32'h1040, 1'b0, 1'b0);
        upd(32'h080, 32'h1080, 1'b0, 1'b0);
        upd(32'h0C0, 32'h10C0, 1'b0, 1'b0);
        probe("evict_040", 32'h040, mk(0, 0, 0, 0, 0, 32'h0));
        probe("keep_080", 32'h080, mk(0, 1, 0, 1, 1, 32'h1080));
        probe("keep_0C0", 32'h0C0, mk(0, 1, 0, 1, 1, 32'h10C0));
        upd(32'h100, 32'h1100, 1'b0, 1'b0);
        probe("evict_080", 32'h080, mk(0, 0, 0, 0, 0, 32'h0));
        probe("new_100", 32'h100, mk(0, 1, 0, 1, 1, 32'h1100));

        // Re-update in place: no allocation, pointer stays on way 0.
        upd(32'h0C0, 32'h300, 1'b0, 1'b0);
        probe("reupd_0C0", 32'h0C0, mk(0, 1, 0, 1, 1, 32'h300));
        probe("reupd_100_kept", 32'h100, mk(0, 1, 0, 1, 1, 32'h1100));
        upd(32'h140, 32'h1140, 1'b1, 1'b0);
        probe("ptr_evicts_0C0", 32'h0C0, mk(0, 0, 0, 0, 0, 32'h0));
        probe("ptr_keeps_100", 32'h100, mk(0, 1, 0, 1, 1, 32'h1100));
        probe("new_140", 32'h140, mk(0, 1, 1, 0, 0, 32'h1140));

        // Full flush walk with updates dropped.
        do_reset();
        upd(32'h000, 32'h3000, 1'b1, 1'b0);
        upd(32'h004, 32'h3004, 1'b1, 1'b0);
        upd(32'h008, 32'h3008, 1'b1, 1'b0);
        upd(32'h00C, 32'h300C, 1'b1, 1'b0);
        upd(32'h03C, 32'h303C, 1'b1, 1'b1);
        probe("fill_004", 32'h004, mk(0, 1, 1, 0, 0, 32'h3004));
        probe("fill_03C", 32'h03C, mk(0, 1, 1, 0, 1, 32'h303C));
        upd_pc = 32'h014; upd_target = 32'h3014; upd_branch = 1'b0; upd_valid = 1'b1;
        pulse_flush();
        upd_pc = 32'h010; upd_target = 32'h3010;
        count_busy(n);
        upd_valid = 1'b0;
        chk("flush_len", vec_t'(n), vec_t'(16));
        probe("post_flush_000", 32'h000, mk(0, 0, 0, 0, 0, 32'h0));
        probe("post_flush_004", 32'h004, mk(0, 0, 0, 0, 0, 32'h0));
        probe("post_flush_008", 32'h008, mk(0, 0, 0, 0, 0, 32'h0));
        probe("post_flush_00C", 32'h00C, mk(0, 0, 0, 0, 0, 32'h0));
        probe("post_flush_03C", 32'h03C, mk(0, 0, 0, 0, 0, 32'h0));
        probe("upd_with_flush", 32'h014, mk(0, 0, 0, 0, 0, 32'h0));
        probe("upd_during_busy", 32'h010, mk(0, 0, 0, 0, 0, 32'h0));

        // Reset mid-walk, then a restarted walk.
        upd(32'h03C, 32'h5000, 1'b0, 1'b0);
        probe("post_walk_hit", 32'h03C, mk(0, 1, 0, 1, 1, 32'h5000));
        pulse_flush();
        repeat (5) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk);
        #1; rst = 1'b0;
        probe("rst_mid_walk", 32'h03C, mk(0, 0, 0, 0, 0, 32'h0));
        upd(32'h03C, 32'h6000, 1'b0, 1'b0);
        probe("rst_then_upd", 32'h03C, mk(0, 1, 0, 1, 1, 32'h6000));
        pulse_flush();
        repeat (8) @(posedge clk);
        #1; flush = 1'b1;
        @(posedge clk);
        #1; flush = 1'b0;
        count_busy(n);
        chk("restart_len", vec_t'(n), vec_t'(16));
        probe("restart_cleared", 32'h03C, mk(0, 0, 0, 0, 0, 32'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
